// File: rtl/vga_timing_controller_if.sv
// Raster coordinates out to the drawers, drawer colour back in, and the
// blanked/expanded colour plus syncs out to the board connector.
interface vga_timing_controller_if #(
  parameter int RGB_WIDTH   = 8,
  parameter int PIXEL_WIDTH = 11
);
  logic [RGB_WIDTH-1:0]   RGB_in;
  logic [PIXEL_WIDTH-1:0] pixelX;
  logic [PIXEL_WIDTH-1:0] pixelY;
  logic                   startOfFrame;
  logic [3:0]             VGA_R;
  logic [3:0]             VGA_G;
  logic [3:0]             VGA_B;
  logic                   VGA_HS;
  logic                   VGA_VS;
  logic                   blank;

  modport master (
    input  RGB_in,
    output pixelX, pixelY, startOfFrame,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, blank
  );

  modport slave (
    output RGB_in,
    input  pixelX, pixelY, startOfFrame,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, blank
  );
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator: coordinates change on each pixel enable; colour,
// sync and blank are registered one pixel period behind the coordinates.
module vga_timing_controller #(
  parameter int RGB_WIDTH   = 8,
  parameter int PIXEL_WIDTH = 11,
  parameter int CLK_DIV     = 2,
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                    clk,
  input  logic                    resetN,
  vga_timing_controller_if.master bus
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PIXEL_WIDTH-1:0] H_LAST   = PIXEL_WIDTH'(H_TOTAL - 1);
  localparam logic [PIXEL_WIDTH-1:0] V_LAST   = PIXEL_WIDTH'(V_TOTAL - 1);
  localparam logic [PIXEL_WIDTH-1:0] H_VIS_P  = PIXEL_WIDTH'(H_VIS);
  localparam logic [PIXEL_WIDTH-1:0] V_VIS_P  = PIXEL_WIDTH'(V_VIS);
  localparam logic [PIXEL_WIDTH-1:0] HS_START = PIXEL_WIDTH'(H_VIS + H_FP);
  localparam logic [PIXEL_WIDTH-1:0] HS_END   = PIXEL_WIDTH'(H_VIS + H_FP + H_SYNC);
  localparam logic [PIXEL_WIDTH-1:0] VS_START = PIXEL_WIDTH'(V_VIS + V_FP);
  localparam logic [PIXEL_WIDTH-1:0] VS_END   = PIXEL_WIDTH'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0]       div_cnt;
  logic [PIXEL_WIDTH-1:0] hcount;
  logic [PIXEL_WIDTH-1:0] vcount;
  logic                   pix_en;
  logic                   h_last;
  logic                   v_last;
  logic                   visible;
  logic                   hs_next;
  logic                   vs_next;
  logic [3:0]             r_next;
  logic [3:0]             g_next;
  logic [3:0]             b_next;

  assign pix_en = (div_cnt == DIV_LAST);
  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // Decode uses the coordinates being retired on this pix_en, which is what
  // puts colour/sync/blank exactly one pixel period behind pixelX/pixelY.
  always_comb begin
    visible = (hcount < H_VIS_P) && (vcount < V_VIS_P);
    hs_next = !((hcount >= HS_START) && (hcount < HS_END));
    vs_next = !((vcount >= VS_START) && (vcount < VS_END));
    r_next  = '0;
    g_next  = '0;
    b_next  = '0;
    if (visible) begin
      r_next = {bus.RGB_in[RGB_WIDTH-1 -: 3], bus.RGB_in[RGB_WIDTH-1]};
      g_next = {bus.RGB_in[RGB_WIDTH-4 -: 3], bus.RGB_in[RGB_WIDTH-4]};
      b_next = {bus.RGB_in[1:0], bus.RGB_in[1:0]};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.VGA_R        <= '0;
      bus.VGA_G        <= '0;
      bus.VGA_B        <= '0;
      bus.VGA_HS       <= 1'b1;
      bus.VGA_VS       <= 1'b1;
      bus.blank        <= 1'b1;
      bus.startOfFrame <= 1'b0;
    end else begin
      bus.startOfFrame <= pix_en && h_last && v_last;
      if (pix_en) begin
        bus.VGA_R  <= r_next;
        bus.VGA_G  <= g_next;
        bus.VGA_B  <= b_next;
        bus.VGA_HS <= hs_next;
        bus.VGA_VS <= vs_next;
        bus.blank  <= !visible;
      end
    end
  end

  assign bus.pixelX = hcount;
  assign bus.pixelY = vcount;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench: a shrunk-raster instance checked pixel by pixel through a scoreboard,
// plus a full 640x480 instance for line timing and drawer latency.
module tb_vga_timing_controller;
  localparam int SH_VIS = 64, SH_FP = 4, SH_SYNC = 8, SH_BP = 4;
  localparam int SV_VIS = 48, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
  localparam int SH_TOT = SH_VIS + SH_FP + SH_SYNC + SH_BP;   // 80
  localparam int SV_TOT = SV_VIS + SV_FP + SV_SYNC + SV_BP;   // 55
  localparam int S_LINE = SH_TOT * 2;
  localparam int S_FRAME = S_LINE * SV_TOT;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [14:0] e;
  } sb_t;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  vga_timing_controller_if #(.RGB_WIDTH(8), .PIXEL_WIDTH(11)) bus_s ();
  vga_timing_controller_if #(.RGB_WIDTH(8), .PIXEL_WIDTH(11)) bus_d ();

  vga_timing_controller #(
    .CLK_DIV(2),
    .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_small (.clk(clk), .resetN(resetN), .bus(bus_s));

  vga_timing_controller u_full (.clk(clk), .resetN(resetN), .bus(bus_d));

  function automatic logic [7:0] pattern(input logic [10:0] x, input logic [10:0] y);
    logic [2:0] k;
    k = x[2:0] + y[2:0];
    if (x == 11'(SH_VIS) || y == 11'(SV_VIS)) return 8'hFF;
    case (k)
      3'd0: return 8'hE0;
      3'd1: return 8'h1C;
      3'd2: return 8'h03;
      3'd3: return 8'hFF;
      3'd4: return 8'h00;
      3'd5: return 8'hA5;
      3'd6: return 8'h5A;
      default: return 8'h49;
    endcase
  endfunction

  function automatic logic [14:0] expect_out(input logic [10:0] x, input logic [10:0] y);
    logic [7:0] c;
    logic vis, hs, vs;
    logic [3:0] r, g, b;
    c   = pattern(x, y);
    vis = (x < 11'(SH_VIS)) && (y < 11'(SV_VIS));
    hs  = !(x >= 11'(SH_VIS + SH_FP) && x < 11'(SH_VIS + SH_FP + SH_SYNC));
    vs  = !(y >= 11'(SV_VIS + SV_FP) && y < 11'(SV_VIS + SV_FP + SV_SYNC));
    r   = vis ? {c[7:5], c[7]} : 4'h0;
    g   = vis ? {c[4:2], c[4]} : 4'h0;
    b   = vis ? {c[1:0], c[1:0]} : 4'h0;
    return {r, g, b, hs, vs, !vis};
  endfunction

  // Drawers register the coordinates and answer one clk later.
  logic [10:0] pxq_s, pyq_s, pxq_d;
  always_ff @(posedge clk) begin
    pxq_s <= bus_s.pixelX;
    pyq_s <= bus_s.pixelY;
    pxq_d <= bus_d.pixelX;
  end
  assign bus_s.RGB_in = pattern(pxq_s, pyq_s);
  assign bus_d.RGB_in = (pxq_d == 11'd20) ? 8'hFF : 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  sb_t q[$];
  bit sb_en = 0, mon_en = 0;
  logic [10:0] lx, ly, lxd;
  logic prev_hs_s, prev_vs_s, prev_sof, prev_hs_d, prev_col_d;
  int hs_fall_s, vs_fall_s, sof_cyc, hs_fall_d, c656, c20, col_start;
  int sof_cnt = 0, xbad = 0;
  int maxx_s = 0, maxy_s = 0, maxx_d = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    q.delete();
    q.push_back('{x: 11'd0, y: 11'd0, e: expect_out(11'd0, 11'd0)});
    lx = '0; ly = '0; lxd = '0;
    prev_hs_s = 1'b1; prev_vs_s = 1'b1; prev_sof = 1'b0;
    prev_hs_d = 1'b1; prev_col_d = 1'b0;
    hs_fall_s = -1; vs_fall_s = -1; sof_cyc = -1; hs_fall_d = -1;
    c656 = -1; c20 = -1; col_start = -1;
    sb_en = 1; mon_en = 1;
  endtask

  task automatic tick();
    logic [14:0] obs;
    logic col_d;
    sb_t e;
    @(negedge clk);
    cyc++;
    obs = {bus_s.VGA_R, bus_s.VGA_G, bus_s.VGA_B, bus_s.VGA_HS, bus_s.VGA_VS, bus_s.blank};
    if (sb_en && (bus_s.pixelX != lx || bus_s.pixelY != ly)) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk($sformatf("sb_pix(%0d,%0d)", e.x, e.y), 32'(obs), 32'(e.e));
        if (e.x == 11'd0 && e.y == 11'd0) chk("rgb_E0", 32'({obs[14:3], obs[0]}), 32'h1E00);
        if (e.x == 11'd1 && e.y == 11'd0) chk("rgb_1C", 32'({obs[14:3], obs[0]}), 32'h01E0);
        if (e.x == 11'd2 && e.y == 11'd0) chk("rgb_03", 32'({obs[14:3], obs[0]}), 32'h001E);
        if (e.x == 11'(SH_VIS) && e.y == 11'd0) chk("blank_x_edge", 32'({obs[14:3], obs[0]}), 32'h1);
        if (e.x == 11'd0 && e.y == 11'(SV_VIS)) chk("blank_y_edge", 32'({obs[14:3], obs[0]}), 32'h1);
      end
      q.push_back('{x: bus_s.pixelX, y: bus_s.pixelY, e: expect_out(bus_s.pixelX, bus_s.pixelY)});
    end
    if (mon_en) begin
      if ($isunknown({bus_s.pixelX, bus_s.pixelY, obs, bus_s.startOfFrame,
                      bus_d.pixelX, bus_d.pixelY, bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B,
                      bus_d.VGA_HS, bus_d.VGA_VS, bus_d.blank, bus_d.startOfFrame})) xbad++;
      if (int'(bus_s.pixelX) > maxx_s) maxx_s = int'(bus_s.pixelX);
      if (int'(bus_s.pixelY) > maxy_s) maxy_s = int'(bus_s.pixelY);
      if (int'(bus_d.pixelX) > maxx_d) maxx_d = int'(bus_d.pixelX);
      if (prev_hs_s && !bus_s.VGA_HS) begin
        if (hs_fall_s >= 0) chk("s_hs_period", 32'(cyc - hs_fall_s), 32'(S_LINE));
        hs_fall_s = cyc;
      end
      if (!prev_hs_s && bus_s.VGA_HS && hs_fall_s >= 0) chk("s_hs_low", 32'(cyc - hs_fall_s), 32'(SH_SYNC * 2));
      if (prev_vs_s && !bus_s.VGA_VS) begin
        if (vs_fall_s >= 0) chk("s_vs_period", 32'(cyc - vs_fall_s), 32'(S_FRAME));
        vs_fall_s = cyc;
      end
      if (!prev_vs_s && bus_s.VGA_VS && vs_fall_s >= 0) chk("s_vs_low", 32'(cyc - vs_fall_s), 32'(SV_SYNC * S_LINE));
      if (bus_s.startOfFrame) begin
        sof_cnt++;
        chk("sof_at_origin", 32'({bus_s.pixelX, bus_s.pixelY}), 32'd0);
        chk("sof_from_last", 32'({lx, ly}), 32'({11'(SH_TOT - 1), 11'(SV_TOT - 1)}));
        chk("sof_one_clk", 32'(prev_sof), 32'd0);
        if (sof_cyc >= 0) chk("frame_period", 32'(cyc - sof_cyc), 32'(S_FRAME));
        sof_cyc = cyc;
      end
      if (bus_d.pixelX == 11'd656 && lxd != 11'd656) c656 = cyc;
      if (bus_d.pixelX == 11'd20 && lxd != 11'd20) c20 = cyc;
      if (prev_hs_d && !bus_d.VGA_HS) begin
        chk("d_hs_after_656", 32'(cyc - c656), 32'd2);
        if (hs_fall_d >= 0) chk("d_hs_period", 32'(cyc - hs_fall_d), 32'd1600);
        hs_fall_d = cyc;
      end
      if (!prev_hs_d && bus_d.VGA_HS && hs_fall_d >= 0) chk("d_hs_low", 32'(cyc - hs_fall_d), 32'd192);
      col_d = |{bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B};
      if (col_d && !prev_col_d) begin
        chk("d_col_start", 32'(cyc - c20), 32'd2);
        chk("d_col_val", 32'({bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B}), 32'hFFF);
        col_start = cyc;
      end
      if (!col_d && prev_col_d) chk("d_col_width", 32'(cyc - col_start), 32'd2);
      prev_col_d = col_d;
    end
    prev_hs_s = bus_s.VGA_HS;
    prev_vs_s = bus_s.VGA_VS;
    prev_sof  = bus_s.startOfFrame;
    prev_hs_d = bus_d.VGA_HS;
    lx = bus_s.pixelX;
    ly = bus_s.pixelY;
    lxd = bus_d.pixelX;
  endtask

  task automatic check_reset_state(input string who, input logic [10:0] x, input logic [10:0] y,
                                   input logic [11:0] rgb, input logic [3:0] ctl);
    chk({who, "_rst_xy"}, 32'({x, y}), 32'd0);
    chk({who, "_rst_rgb"}, 32'(rgb), 32'd0);
    chk({who, "_rst_hs_vs_blank_sof"}, 32'(ctl), 32'b1110);
  endtask

  initial begin
    int n;
    #2 resetN = 1'b0;
    #1;
    check_reset_state("s", bus_s.pixelX, bus_s.pixelY, {bus_s.VGA_R, bus_s.VGA_G, bus_s.VGA_B},
                      {bus_s.VGA_HS, bus_s.VGA_VS, bus_s.blank, bus_s.startOfFrame});
    check_reset_state("d", bus_d.pixelX, bus_d.pixelY, {bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B},
                      {bus_d.VGA_HS, bus_d.VGA_VS, bus_d.blank, bus_d.startOfFrame});
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    start_run();
    tick();
    chk("rel_x_hold", 32'(bus_s.pixelX), 32'd0);
    chk("rel_blank_hold", 32'(bus_s.blank), 32'd1);
    tick();
    chk("rel_x_step", 32'(bus_s.pixelX), 32'd1);
    chk("rel_blank_first", 32'(bus_s.blank), 32'd0);
    for (int i = 0; i < 2 * S_FRAME + 100; i++) tick();
    chk("sof_count", 32'(sof_cnt), 32'd2);

    // Mid-line reset on the full raster.
    sb_en = 0; mon_en = 0;
    n = 0;
    while (bus_d.pixelX != 11'd300 && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_x300", 32'(bus_d.pixelX), 32'd300);
    resetN = 1'b0;
    #1;
    check_reset_state("d_mid", bus_d.pixelX, bus_d.pixelY, {bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B},
                      {bus_d.VGA_HS, bus_d.VGA_VS, bus_d.blank, bus_d.startOfFrame});
    check_reset_state("s_mid", bus_s.pixelX, bus_s.pixelY, {bus_s.VGA_R, bus_s.VGA_G, bus_s.VGA_B},
                      {bus_s.VGA_HS, bus_s.VGA_VS, bus_s.blank, bus_s.startOfFrame});
    repeat (2) tick();
    resetN = 1'b1;
    start_run();
    tick();
    chk("mid_rel_x_hold", 32'(bus_d.pixelX), 32'd0);
    tick();
    chk("mid_rel_x_step", 32'(bus_d.pixelX), 32'd1);
    for (int i = 0; i < 400; i++) tick();

    chk("max_x_small", 32'(maxx_s), 32'(SH_TOT - 1));
    chk("max_y_small", 32'(maxy_s), 32'(SV_TOT - 1));
    chk("max_x_full", 32'(maxx_d), 32'd799);
    chk("no_x_outputs", 32'(xbad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
